// File: rtl/snow64_scalar_access_scheduler_if.sv
// rtl/snow64_scalar_access_scheduler_if.sv - extractor/injector port types and requester-side bus
//
// snow64_scalar_access_pkg holds the packed port structs of the external
// scalar data extractor and injector.
//
// snow64_scalar_access_scheduler_if bundles the two requesters' request lanes
// with the shared response channel. Lane N of every packed vector belongs
// to requester N.
//   req_valid / req_ready          per-lane request handshake
//   req_is_inject                  1 = read-modify-write inject, 0 = extract
//   req_lar_index                  target LAR, WIDTH__LAR_INDEX bits per lane
//   req_data_type                  CPU data type, 2 bits per lane
//   req_int_type_size              0=8b 1=16b 2=32b 3=64b, 2 bits per lane
//   req_data_offset                byte offset in the 256-bit line, 5 bits per lane
//   req_scalar                     inject value, 64 bits per lane
//   resp_valid / resp_ready        response handshake
//   resp_id / resp_scalar          owning requester, element value before modification
// modport master: requester side. modport slave: scheduler side.

package snow64_scalar_access_pkg;
    typedef struct packed {
        logic [255:0] to_shift;
        logic [1:0]   data_type;
        logic [1:0]   int_type_size;
        logic [4:0]   data_offset;
    } PortIn_ScalarDataExtractor;

    typedef struct packed {
        logic [63:0] data;
    } PortOut_ScalarDataExtractor;

    typedef struct packed {
        logic [255:0] to_modify;
        logic [63:0]  to_shift;
        logic [1:0]   data_type;
        logic [1:0]   int_type_size;
        logic [4:0]   data_offset;
    } PortIn_ScalarDataInjector;

    typedef struct packed {
        logic [255:0] data;
    } PortOut_ScalarDataInjector;
endpackage

interface snow64_scalar_access_scheduler_if #(
    parameter int WIDTH__LAR_INDEX = 4
) ();
    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0]                    req_is_inject;
    logic [2*WIDTH__LAR_INDEX-1:0] req_lar_index;
    logic [3:0]                    req_data_type;
    logic [3:0]                    req_int_type_size;
    logic [9:0]                    req_data_offset;
    logic [127:0]                  req_scalar;
    logic                          resp_valid;
    logic                          resp_ready;
    logic                          resp_id;
    logic [63:0]                   resp_scalar;

    modport master (
        output req_valid, req_is_inject, req_lar_index, req_data_type,
               req_int_type_size, req_data_offset, req_scalar, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_scalar
    );

    modport slave (
        input  req_valid, req_is_inject, req_lar_index, req_data_type,
               req_int_type_size, req_data_offset, req_scalar, resp_ready,
        output req_ready, resp_valid, resp_id, resp_scalar
    );
endinterface

// File: rtl/snow64_scalar_access_scheduler.sv
// rtl/snow64_scalar_access_scheduler.sv - round-robin scheduler sharing one scalar extractor/injector and LAR port pair
//
// Serves one scalar extract or read-modify-write inject at a time through
// IDLE -> RD -> EXEC -> (WR) -> RESP, arbitrating two requesters round-robin.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   bus (slave modport)             request lanes and response channel
//   lar_rd_en/lar_rd_index          LAR read, data returns on lar_rd_data next cycle
//   lar_wr_en/lar_wr_index/lar_wr_data  LAR write
//   ext_in/ext_out                  external scalar extractor (combinational)
//   inj_in/inj_out                  external scalar injector (combinational)
// Optional feature macro: SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN adds a one-entry
// line cache that lets hits skip RD, plus the lar_ext_wr invalidate input.

module snow64_scalar_access_scheduler
    import snow64_scalar_access_pkg::*;
#(
    parameter int WIDTH__LAR_INDEX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    snow64_scalar_access_scheduler_if.slave bus,
    output logic                        lar_rd_en,
    output logic [WIDTH__LAR_INDEX-1:0] lar_rd_index,
    input  logic [255:0]                lar_rd_data,
    output logic                        lar_wr_en,
    output logic [WIDTH__LAR_INDEX-1:0] lar_wr_index,
    output logic [255:0]                lar_wr_data,
`ifdef SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN
    input  logic                        lar_ext_wr,
`endif
    output PortIn_ScalarDataExtractor   ext_in,
    input  PortOut_ScalarDataExtractor  ext_out,
    output PortIn_ScalarDataInjector    inj_in,
    input  PortOut_ScalarDataInjector   inj_out
);
    localparam int W = WIDTH__LAR_INDEX;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EXEC, S_WR, S_RESP} state_t;

    state_t        state_q, state_d;
    logic          rr_q;
    logic          id_q;
    logic          is_inject_q;
    logic [W-1:0]  idx_q;
    logic [1:0]    dtype_q;
    logic [1:0]    size_q;
    logic [4:0]    off_q;
    logic [63:0]   scalar_q;
    logic [63:0]   resp_scalar_q;
    logic [255:0]  wr_data_q;

    logic          grant;
    logic          gnt_id;
    logic [W-1:0]  gnt_idx;
    logic          hit;
    logic [255:0]  exec_line;

`ifdef SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN
    logic          cache_vld_q;
    logic [W-1:0]  cache_idx_q;
    logic [255:0]  cache_line_q;
    logic          use_cache_q;
`endif

    // Arbitration: a lone requester wins outright; on contention the pointer decides.
    always_comb begin
        grant   = (state_q == S_IDLE) && (|bus.req_valid);
        gnt_id  = (&bus.req_valid) ? rr_q : bus.req_valid[1];
        gnt_idx = gnt_id ? bus.req_lar_index[2*W-1:W] : bus.req_lar_index[W-1:0];
`ifdef SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN
        // A same-cycle external write makes the cached line stale, so no hit.
        hit       = cache_vld_q && !lar_ext_wr && (cache_idx_q == gnt_idx);
        exec_line = use_cache_q ? cache_line_q : lar_rd_data;
`else
        hit       = 1'b0;
        exec_line = lar_rd_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant) state_d = hit ? S_EXEC : S_RD;
            S_RD:   state_d = S_EXEC;
            S_EXEC: state_d = is_inject_q ? S_WR : S_RESP;
            S_WR:   state_d = S_RESP;
            S_RESP: if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are zero outside their owning state; req_ready is also masked
    // during reset because the state register already reads IDLE then.
    always_comb begin
        bus.req_ready   = 2'b00;
        bus.resp_valid  = (state_q == S_RESP);
        bus.resp_id     = id_q;
        bus.resp_scalar = resp_scalar_q;
        lar_rd_en       = 1'b0;
        lar_rd_index    = '0;
        lar_wr_en       = 1'b0;
        lar_wr_index    = '0;
        lar_wr_data     = '0;
        ext_in          = '0;
        inj_in          = '0;
        if (grant && rst_n) bus.req_ready = gnt_id ? 2'b10 : 2'b01;
        case (state_q)
            S_RD: begin
                lar_rd_en    = 1'b1;
                lar_rd_index = idx_q;
            end
            S_EXEC: begin
                ext_in.to_shift      = exec_line;
                ext_in.data_type     = dtype_q;
                ext_in.int_type_size = size_q;
                ext_in.data_offset   = off_q;
                inj_in.to_modify     = exec_line;
                inj_in.to_shift      = scalar_q;
                inj_in.data_type     = dtype_q;
                inj_in.int_type_size = size_q;
                inj_in.data_offset   = off_q;
            end
            S_WR: begin
                lar_wr_en    = 1'b1;
                lar_wr_index = idx_q;
                lar_wr_data  = wr_data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= 1'b0;
            id_q          <= 1'b0;
            is_inject_q   <= 1'b0;
            idx_q         <= '0;
            dtype_q       <= '0;
            size_q        <= '0;
            off_q         <= '0;
            scalar_q      <= '0;
            resp_scalar_q <= '0;
            wr_data_q     <= '0;
        end else begin
            if (grant) begin
                rr_q        <= ~gnt_id;
                id_q        <= gnt_id;
                is_inject_q <= bus.req_is_inject[gnt_id];
                idx_q       <= gnt_idx;
                dtype_q     <= gnt_id ? bus.req_data_type[3:2]     : bus.req_data_type[1:0];
                size_q      <= gnt_id ? bus.req_int_type_size[3:2] : bus.req_int_type_size[1:0];
                off_q       <= gnt_id ? bus.req_data_offset[9:5]   : bus.req_data_offset[4:0];
                scalar_q    <= gnt_id ? bus.req_scalar[127:64]     : bus.req_scalar[63:0];
            end
            if (state_q == S_EXEC) begin
                resp_scalar_q <= ext_out.data;
                wr_data_q     <= inj_out.data;
            end
        end
    end

`ifdef SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q  <= 1'b0;
            cache_idx_q  <= '0;
            cache_line_q <= '0;
            use_cache_q  <= 1'b0;
        end else begin
            if (grant) use_cache_q <= hit;
            if (state_q == S_EXEC || state_q == S_WR) begin
                cache_idx_q  <= idx_q;
                cache_line_q <= (state_q == S_WR) ? wr_data_q : exec_line;
            end
            if (lar_ext_wr)                                  cache_vld_q <= 1'b0;
            else if (state_q == S_EXEC || state_q == S_WR)   cache_vld_q <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/snow64_scalar_access_scheduler.md
# snow64_scalar_access_scheduler

Sequencer and arbiter that shares one scalar data extractor/injector pair and one LAR-file read/write port pair between two requesters. Each accepted request is a scalar extract or a read-modify-write scalar inject on a 256-bit LAR data line. The block sits between the LAR file and its scalar consumers, which are the execute-stage ALU writeback on port 0 and the load/store unit on port 1. Requests are served one at a time through a small FSM, with round-robin fairness.

## Interface
Parameters:
- WIDTH__LAR_INDEX, default 4: LAR index width, giving 16 LARs.

Ports. Lane N of each packed vector belongs to requester N, N in {0,1}.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  request present, one bit per requester.
- req_ready  out  2  request accepted this cycle; at most one bit set.
- req_is_inject  in  2  1 = inject, 0 = extract.
- req_lar_index  in  2*WIDTH__LAR_INDEX  target LAR.
- req_data_type  in  2*2  CPU data type.
- req_int_type_size  in  2*2  int size code: 0=8b, 1=16b, 2=32b, 3=64b.
- req_data_offset  in  2*5  byte offset into the line.
- req_scalar  in  2*64  value to inject; ignored for extract.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_id  out  1  requester the response belongs to.
- resp_scalar  out  64  element value read before any modification.
- lar_rd_en, lar_rd_index  out  1, WIDTH__LAR_INDEX  LAR read; data returns one cycle later.
- lar_rd_data  in  256  read data.
- lar_wr_en, lar_wr_index, lar_wr_data  out  1, WIDTH__LAR_INDEX, 256  LAR write.
- ext_in  out  PortIn_ScalarDataExtractor  drives the external extractor.
- ext_out  in  PortOut_ScalarDataExtractor  extractor result, combinational.
- inj_in  out  PortIn_ScalarDataInjector  drives the external injector.
- inj_out  in  PortOut_ScalarDataInjector  injector result, combinational.

## Operation
- States: IDLE, RD, EXEC, WR, RESP.
- IDLE:
  - Grant one valid requester: if only one is valid, grant it; if both are valid, grant the one selected by the round-robin pointer.
  - On grant, assert req_ready for that lane only; latch the request fields and id; toggle the pointer to the other requester; go to RD.
  - The pointer resets to 0.
- RD: lar_rd_en=1 and lar_rd_index=latched index; go to EXEC.
- EXEC:
  - ext_in.to_shift=lar_rd_data. inj_in.to_modify=lar_rd_data. inj_in.to_shift=latched scalar. Type, size and offset come from the latched request.
  - Latch ext_out.data into resp_scalar and inj_out.data into the write-data register.
  - Next state: WR if inject, else RESP.
- WR: lar_wr_en=1 with the latched index and data for exactly one cycle; go to RESP.
- RESP: resp_valid=1; hold resp_id and resp_scalar stable until resp_ready=1, then go to IDLE.
- req_ready stays 0 outside IDLE. A requester holding req_valid keeps its fields stable until it sees req_ready.
- ext_in and inj_in may take any value outside EXEC. lar_rd_en and lar_wr_en must be 0 outside RD and WR respectively.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight request is dropped. No LAR write may occur after rst_n falls, including the case where reset arrives during WR.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_scalar=0, lar_rd_en=0, lar_rd_index=0, lar_wr_en=0, lar_wr_index=0, lar_wr_data=0, ext_in=0, inj_in=0.
- Handshake at cycle T: RD at T+1, EXEC at T+2. For an extract, RESP at T+3; for an inject, WR at T+3 and RESP at T+4.
- resp_ready already high on the first RESP cycle: the response completes that cycle and IDLE may grant again on the next cycle.
- Minimum spacing between grants is 4 cycles for extract and 5 for inject.
- Back-to-back inject then extract on the same LAR: the extract must observe the injected data. The LAR file must make a write visible to a read issued at least one cycle later.

## Configuration
- SNOW64_SCALAR_ACCESS_SCHED_FORWARD_EN defined:
  - The block keeps a one-entry line cache (index, 256-bit line, valid bit), loaded on every WR and on every EXEC.
  - A granted request whose index hits a valid entry skips RD and goes IDLE to EXEC, using the cached line. Hit latency is 1 cycle shorter.
  - An extra input, lar_ext_wr (1 bit), clears the valid bit. When it coincides with a cache load, the clear wins.
  - The valid bit resets to 0.
- Undefined: no cache and no lar_ext_wr port; every request passes through RD.

## Test plan
- Extract, port 0: LAR 3 = 0x...1122334455667788, size 1, offset 2, unsigned. Required: lar_rd_en at T+1, resp_valid at T+3, resp_scalar=0x5566, resp_id=0.
- Inject, port 1: LAR 5 line all zeros, scalar 0xAB, size 0, offset 31. Required: lar_wr_en at T+3, lar_wr_data byte 31=0xAB and all other bytes 0, resp_scalar=0 at T+4.
- Both ports valid continuously with resp_ready=1. Required: grants alternate 0,1,0,1 starting at 0 after reset, with no lane starved.
- resp_ready held low 5 cycles in RESP. Required: resp_valid, resp_id and resp_scalar stable throughout; req_ready stays 0 until the cycle after resp_ready.
- rst_n dropped in WR of an inject. Required: lar_wr_en=0 immediately, all outputs at reset values, IDLE after release.
- With FORWARD_EN: inject then extract on LAR 7. Required: the extract skips RD and resp_valid arrives at T+2. Repeat with a lar_ext_wr pulse between the two requests; required: RD is taken.
